// File: rtl/alu_result_sink_if.sv
// Handshake and bus bundle between the control unit/ALU, the result sink and the datapath bus.
// The master drives the ALU result and bus-ready; the slave (the sink) drives ready and the bus beat.
interface alu_result_sink_if #(
  parameter int DATA_W = 32
);
  logic              iValid;
  logic              oReady;
  logic [DATA_W-1:0] iC_hi;
  logic [DATA_W-1:0] iC_lo;
  logic              iZero;
  logic              iNeg;
  logic              iWide;
  logic [DATA_W-1:0] oBus;
  logic              oBusValid;
  logic              iBusReady;

  modport master (
    output iValid, iC_hi, iC_lo, iZero, iNeg, iWide, iBusReady,
    input  oReady, oBus, oBusValid
  );

  modport slave (
    input  iValid, iC_hi, iC_lo, iZero, iNeg, iWide, iBusReady,
    output oReady, oBus, oBusValid
  );
endinterface

// File: rtl/alu_result_sink.sv
// Registered sink for the ALU result: captures one result, drains it as LO (then HI) bus beats.
// Optional macro ALU_SINK_PIPE_EN lets a new result be captured while the final beat is accepted.
module alu_result_sink #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  alu_result_sink_if.slave  bus,
  output logic [DATA_W-1:0] oHI,
  output logic [DATA_W-1:0] oLO,
  output logic              oFlagZ,
  output logic              oFlagN,
  output logic              oDone,
  output logic              oErr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER_LO = 2'd1,
    XFER_HI = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] zhi_q, zhi_d;
  logic [DATA_W-1:0] zlo_q, zlo_d;
  logic              wide_q, wide_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic              bus_vld_q, bus_vld_d;

  logic final_beat;
  logic ready;
  logic capture;
  logic timeout_hit;

  assign final_beat  = (state_q == XFER_HI) || ((state_q == XFER_LO) && !wide_q);
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

`ifdef ALU_SINK_PIPE_EN
  // Combinational iBusReady -> oReady path: the slot frees up the cycle the last beat is taken.
  assign ready = (state_q == IDLE) || (final_beat && bus.iBusReady);
`else
  assign ready = (state_q == IDLE);
`endif

  assign capture = bus.iValid && ready;

  always_comb begin
    state_d  = state_q;
    zhi_d    = zhi_q;
    zlo_d    = zlo_q;
    wide_d   = wide_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      XFER_LO: begin
        if (bus.iBusReady) begin
          cnt_d = '0;
          if (wide_q) begin
            lo_d    = zlo_q;
            state_d = XFER_HI;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER_HI: begin
        if (bus.iBusReady) begin
          cnt_d   = '0;
          hi_d    = zhi_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase

    // Capture overrides the IDLE return so a pipelined result starts its LO beat directly.
    if (capture) begin
      zhi_d    = bus.iC_hi;
      zlo_d    = bus.iC_lo;
      wide_d   = bus.iWide;
      flag_z_d = bus.iZero;
      flag_n_d = bus.iNeg;
      cnt_d    = '0;
      state_d  = XFER_LO;
    end

    // Bus beat is registered from the next state so it is stable while the bus stalls.
    bus_vld_d = (state_d != IDLE);
    case (state_d)
      XFER_LO: bus_d = zlo_d;
      XFER_HI: bus_d = zhi_d;
      default: bus_d = '0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= IDLE;
      zhi_q     <= '0;
      zlo_q     <= '0;
      wide_q    <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bus_q     <= '0;
      bus_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      zhi_q     <= zhi_d;
      zlo_q     <= zlo_d;
      wide_q    <= wide_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      bus_q     <= bus_d;
      bus_vld_q <= bus_vld_d;
    end
  end

  assign bus.oReady    = ready;
  assign bus.oBus      = bus_q;
  assign bus.oBusValid = bus_vld_q;
  assign oHI           = hi_q;
  assign oLO           = lo_q;
  assign oFlagZ        = flag_z_q;
  assign oFlagN        = flag_n_q;
  assign oDone         = done_q;
  assign oErr          = err_q;

endmodule

// File: tb/tb_alu_result_sink.sv
// Directed and randomized bench for alu_result_sink against a transaction-level model.
module tb_alu_result_sink;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_result_sink_if #(.DATA_W(DATA_W)) bus ();
  logic [DATA_W-1:0] hi_o, lo_o;
  logic fz_o, fn_o, done_o, err_o;

  alu_result_sink #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .iClk(clk), .iRst(rst), .bus(bus),
    .oHI(hi_o), .oLO(lo_o), .oFlagZ(fz_o), .oFlagN(fn_o),
    .oDone(done_o), .oErr(err_o)
  );

  int errors = 0;
  int checks = 0;

  // Architectural state expected by the model.
  logic [DATA_W-1:0] m_hi, m_lo;
  logic m_z, m_n;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, "_hi"}, hi_o, m_hi);
    chk({tag, "_lo"}, lo_o, m_lo);
    chk({tag, "_z"}, fz_o, m_z);
    chk({tag, "_n"}, fn_o, m_n);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, bus.oBusValid, 1'b0);
    chk({tag, "_bus"}, bus.oBus, '0);
    chk({tag, "_rdy"}, bus.oReady, 1'b1);
  endtask

  // Present one beat of data d, stalled for 'stall' cycles; reports whether it was aborted.
  task automatic beat(input logic [DATA_W-1:0] d, input int stall, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < stall && !aborted; i++) begin
      bus.iBusReady = 1'b0;
      bus.iValid    = 1'b1;          // must be ignored while a beat is pending
      bus.iC_hi     = $urandom;
      bus.iC_lo     = $urandom;
      bus.iZero     = 1'($urandom);
      bus.iNeg      = 1'($urandom);
      bus.iWide     = 1'($urandom);
      chk("stall_vld", bus.oBusValid, 1'b1);
      chk("stall_data", bus.oBus, d);
      chk("stall_rdy", bus.oReady, 1'b0);
      chk("stall_done", done_o, 1'b0);
      step();
      bus.iValid = 1'b0;
      chk("stall_err", err_o, (i + 1 == TIMEOUT));
      if (i + 1 == TIMEOUT) aborted = 1'b1;
    end
    if (!aborted) begin
      bus.iBusReady = 1'b1;
      chk("beat_vld", bus.oBusValid, 1'b1);
      chk("beat_data", bus.oBus, d);
      step();
      bus.iBusReady = 1'b0;
      chk("beat_err", err_o, 1'b0);
    end
  endtask

  task automatic txn(input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                     input logic z, input logic n, input logic wide,
                     input int stall_lo, input int stall_hi);
    bit ab;
    bus.iValid = 1'b1; bus.iC_hi = hi; bus.iC_lo = lo;
    bus.iZero = z; bus.iNeg = n; bus.iWide = wide; bus.iBusReady = 1'b0;
    chk("cap_rdy", bus.oReady, 1'b1);
    step();
    bus.iValid = 1'b0; bus.iC_hi = $urandom; bus.iC_lo = $urandom;
    m_z = z; m_n = n;
    chk_arch("cap");
    beat(lo, stall_lo, ab);
    if (!ab && wide) begin
      m_lo = lo;
      chk_arch("lo_acc");
      chk("lo_acc_done", done_o, 1'b0);
      beat(hi, stall_hi, ab);
      if (!ab) m_hi = hi;
    end
    chk("end_done", done_o, !ab);
    chk_idle("end");
    chk_arch("end");
    bus.iBusReady = 1'($urandom);    // ignored while no beat is presented
    step();
    bus.iBusReady = 1'b0;
    chk("post_done", done_o, 1'b0);
    chk("post_err", err_o, 1'b0);
    chk_idle("post");
  endtask

  initial begin
    rst = 1'b1;
    bus.iValid = 1'b0; bus.iC_hi = '0; bus.iC_lo = '0;
    bus.iZero = 1'b0; bus.iNeg = 1'b0; bus.iWide = 1'b0; bus.iBusReady = 1'b0;
    m_hi = '0; m_lo = '0; m_z = 1'b0; m_n = 1'b0;
    step();
    step();
    chk_idle("rst");
    chk_arch("rst");
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    rst = 1'b0;
    step();

    // Narrow ADD, wide MUL, stalls, boundary and timeouts.
    txn(32'h0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 0, 0);
    txn(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 0, 0);
    txn(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b1, 0, 5);
    txn(32'h0, 32'h0000_00AA, 1'b1, 1'b1, 1'b0, TIMEOUT - 1, 0);
    txn(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, TIMEOUT, 0);
    txn(32'h0BAD_0BAD, 32'h600D_600D, 1'b1, 1'b0, 1'b1, 2, TIMEOUT);

    // Reset while the HI beat is pending after the LO beat was accepted.
    bus.iValid = 1'b1; bus.iC_hi = 32'h5555_0001; bus.iC_lo = 32'h5555_0002;
    bus.iZero = 1'b1; bus.iNeg = 1'b1; bus.iWide = 1'b1;
    step();
    bus.iValid = 1'b0; bus.iBusReady = 1'b1;
    step();
    bus.iBusReady = 1'b0;
    chk("mid_lo", lo_o, 32'h5555_0002);
    chk("mid_hibeat", bus.oBus, 32'h5555_0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_z = 1'b0; m_n = 1'b0;
    chk_idle("midrst");
    chk_arch("midrst");
    step();
    chk_idle("midrst2");

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      int sl, sh;
      sl = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
      sh = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
      txn($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), sl, sh);
    end

`ifdef ALU_SINK_PIPE_EN
    // Back-to-back narrow results on consecutive cycles.
    bus.iValid = 1'b1; bus.iC_lo = 32'h1; bus.iC_hi = '0; bus.iWide = 1'b0;
    bus.iZero = 1'b0; bus.iNeg = 1'b0;
    step();
    bus.iBusReady = 1'b1; bus.iC_lo = 32'h2;
    chk("pipe_bus1", bus.oBus, 32'h1);
    chk("pipe_rdy", bus.oReady, 1'b1);
    step();
    bus.iValid = 1'b0;
    chk("pipe_bus2", bus.oBus, 32'h2);
    chk("pipe_vld2", bus.oBusValid, 1'b1);
    chk("pipe_done1", done_o, 1'b1);
    step();
    bus.iBusReady = 1'b0;
    chk("pipe_done2", done_o, 1'b1);
    chk_idle("pipe_end");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_result_sink.md
Name: alu_result_sink

Overview:
- Registered consumer of the ALU's combinational 64-bit result (oC_hi/oC_lo) and its flags (oZero/oNeg).
- Captures one result per handshake into an internal Z pair and latches the Z/N flags.
- Drains the result onto the datapath bus as one beat (32-bit ops) or two beats, LO then HI (MUL/DIV).
- For wide results, also updates the architectural HI/LO registers. Sits between the ALU and the internal bus and is sequenced by the control unit.

Parameters:
- DATA_W, 32, width of each result half and of the bus.
- TIMEOUT, 16, bus-stall cycles tolerated per beat before abort; 0 disables the timeout.

Ports:
- iClk  input  1  clock; all state changes on the rising edge.
- iRst  input  1  synchronous reset, active-high.
- iValid  input  1  control unit presents an ALU result this cycle.
- oReady  output  1  block can accept a result.
- iC_hi  input  DATA_W  ALU high result half.
- iC_lo  input  DATA_W  ALU low result half.
- iZero  input  1  ALU zero flag.
- iNeg  input  1  ALU negative flag.
- iWide  input  1  1 = MUL/DIV result, two beats, HI/LO write; 0 = single beat.
- oBus  output  DATA_W  bus data; 0 when oBusValid=0.
- oBusValid  output  1  bus beat present.
- iBusReady  input  1  bus accepts the current beat this cycle.
- oHI  output  DATA_W  architectural HI register.
- oLO  output  DATA_W  architectural LO register.
- oFlagZ  output  1  latched zero flag.
- oFlagN  output  1  latched negative flag.
- oDone  output  1  one-cycle pulse: final beat accepted.
- oErr  output  1  one-cycle pulse: beat aborted on timeout.

Behaviour:
- Synchronous active-high reset on iRst:
  - Reset values: state=IDLE; oReady=1; oBus=0; oBusValid=0; oHI=0; oLO=0; oFlagZ=0; oFlagN=0; oDone=0; oErr=0.
  - Internal zhi/zlo/wide/stall counter are cleared.
  - Reset has priority over every other event. A result in flight is dropped and no HI/LO write occurs.
- States: IDLE, XFER_LO, XFER_HI.
- IDLE:
  - oReady=1, oBusValid=0.
  - On iValid=1: zhi<=iC_hi, zlo<=iC_lo, wide<=iWide, oFlagZ<=iZero, oFlagN<=iNeg; go to XFER_LO.
  - iValid is ignored in every other state while oReady=0; the control unit holds the result.
- XFER_LO:
  - oBus=zlo, oBusValid=1, oReady=0.
  - On iBusReady=1: if wide, oLO<=zlo and go to XFER_HI; else oDone=1 next cycle and go to IDLE.
- XFER_HI:
  - oBus=zhi, oBusValid=1.
  - On iBusReady=1: oHI<=zhi, oDone=1 next cycle, go to IDLE.
- Latency:
  - Capture in cycle N; first beat is visible in cycle N+1.
  - With iBusReady held at 1: narrow result back in IDLE at N+2; wide result at N+3.
  - Minimum issue interval: 2 cycles narrow, 3 cycles wide.
- oBus/oBusValid are registered and stable while iBusReady=0 (hold rule).
- Stall counter:
  - Increments each cycle a beat is presented with iBusReady=0; clears on beat acceptance or state change.
  - If TIMEOUT>0 and the counter reaches TIMEOUT: abort to IDLE and pulse oErr.
  - On abort, no further HI/LO write occurs. An oLO written by an accepted LO beat is kept.
- Flags hold their value until the next capture. They are not cleared by beat completion.
- iBusReady while oBusValid=0 is ignored.

Optional Feature:
- Macro: ALU_SINK_PIPE_EN.
- Defined:
  - oReady is also 1 in the final-beat state (XFER_LO with wide=0, or XFER_HI) when iBusReady=1. This is a combinational path from iBusReady to oReady.
  - A simultaneous iValid captures the new result and goes directly to XFER_LO, skipping IDLE.
  - oDone still pulses for the completed result.
  - Issue interval becomes 1 cycle narrow, 2 cycles wide.
- Undefined: oReady=1 only in IDLE, as described above.

Test Plan:
- Reset then idle: iRst=1 for 2 cycles -> all outputs 0, oReady=1; oHI=oLO=0.
- Narrow ADD: iValid, iWide=0, iC_lo=0x00000005, iC_hi=0, iZero=0, iNeg=0, iBusReady=1 -> one beat oBus=0x00000005 at N+1; oDone at N+2; oLO unchanged; oFlagZ=0.
- Wide MUL:
  - Stimulus: iWide=1, iC_hi=0xFFFFFFFF, iC_lo=0xFFFFFFFE, iNeg=1.
  - Response: beats 0xFFFFFFFE then 0xFFFFFFFF; oLO=0xFFFFFFFE, oHI=0xFFFFFFFF; oFlagN=1; oDone one cycle after the HI beat.
- Bus stall: wide capture, iBusReady=0 for 5 cycles during XFER_HI -> oBus holds zhi, oHI unchanged until acceptance; no oErr.
- Timeout: TIMEOUT=4, iBusReady=0 for 4 cycles in XFER_LO -> oErr pulse, return to IDLE, oLO/oHI unchanged, oBusValid=0.
- Reset mid-transfer: iRst in XFER_HI after LO accepted -> next cycle IDLE, oHI=0, oLO=0, oBusValid=0. With ALU_SINK_PIPE_EN: back-to-back narrow results 0x1, 0x2 -> beats on consecutive cycles.
